// File: rtl/command_source_arbiter.sv
// rtl/command_source_arbiter.sv - two-source, frame-atomic round-robin arbiter for the command byte input
module command_source_arbiter #(
    parameter int FRAME_TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  s0_byte,
    input  logic        s0_valid,
    input  logic        s0_last,
    output logic        s0_ready,
    input  logic [7:0]  s1_byte,
    input  logic        s1_valid,
    input  logic        s1_last,
    output logic        s1_ready,
    output logic [7:0]  ctrl_byte,
    output logic        ctrl_valid,
    input  logic        ctrl_next,
    output logic        grant,
    output logic        busy,
    output logic        abort,
    output logic        abort_src,
    output logic [15:0] bytes_fwd
);

    localparam int CW = (FRAME_TIMEOUT_CYCLES > 2) ? $clog2(FRAME_TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] TMO_LAST = CW'(FRAME_TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_GRANTED   = 2'd1,
        ST_WAIT_NEXT = 2'd2
    } state_t;

    state_t        state_q;
    logic          last_granted_q;
    logic          last_flag_q;
    logic [CW-1:0] tmo_q;
    logic          s0_ready_q;
    logic          s1_ready_q;
    logic [7:0]    ctrl_byte_q;
    logic          ctrl_valid_q;
    logic          grant_q;
    logic          busy_q;
    logic          abort_q;
    logic          abort_src_q;
    logic [15:0]   bytes_fwd_q;

    logic          sel_valid;
    logic [7:0]    sel_byte;
    logic          sel_last;

    // Only the granted source is ever looked at while a frame is open.
    assign sel_valid = grant_q ? s1_valid : s0_valid;
    assign sel_byte  = grant_q ? s1_byte  : s0_byte;
    assign sel_last  = grant_q ? s1_last  : s0_last;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            last_granted_q <= 1'b1;
            last_flag_q    <= 1'b0;
            tmo_q          <= '0;
            s0_ready_q     <= 1'b0;
            s1_ready_q     <= 1'b0;
            ctrl_byte_q    <= 8'h00;
            ctrl_valid_q   <= 1'b0;
            grant_q        <= 1'b0;
            busy_q         <= 1'b0;
            abort_q        <= 1'b0;
            abort_src_q    <= 1'b0;
            bytes_fwd_q    <= 16'h0000;
        end else begin
            s0_ready_q <= 1'b0;
            s1_ready_q <= 1'b0;
            abort_q    <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (s0_valid || s1_valid) begin
                        grant_q <= (s0_valid && s1_valid) ? ~last_granted_q : s1_valid;
                        busy_q  <= 1'b1;
                        tmo_q   <= '0;
                        state_q <= ST_GRANTED;
                    end
                end
                ST_GRANTED: begin
                    if (sel_valid) begin
                        ctrl_byte_q  <= sel_byte;
                        last_flag_q  <= sel_last;
                        ctrl_valid_q <= 1'b1;
                        s0_ready_q   <= ~grant_q;
                        s1_ready_q   <= grant_q;
                        tmo_q        <= '0;
                        state_q      <= ST_WAIT_NEXT;
                    end else if (tmo_q == TMO_LAST) begin
                        abort_q        <= 1'b1;
                        abort_src_q    <= grant_q;
                        last_granted_q <= grant_q;
                        busy_q         <= 1'b0;
                        tmo_q          <= '0;
                        state_q        <= ST_IDLE;
                    end else begin
                        tmo_q <= tmo_q + CW'(1);
                    end
                end
                ST_WAIT_NEXT: begin
                    if (ctrl_next) begin
                        ctrl_valid_q <= 1'b0;
                        bytes_fwd_q  <= bytes_fwd_q + 16'd1;
                        if (last_flag_q) begin
                            last_granted_q <= grant_q;
                            busy_q         <= 1'b0;
                            state_q        <= ST_IDLE;
                        end else begin
                            state_q <= ST_GRANTED;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign s0_ready   = s0_ready_q;
    assign s1_ready   = s1_ready_q;
    assign ctrl_byte  = ctrl_byte_q;
    assign ctrl_valid = ctrl_valid_q;
    assign grant      = grant_q;
    assign busy       = busy_q;
    assign abort      = abort_q;
    assign abort_src  = abort_src_q;
    assign bytes_fwd  = bytes_fwd_q;

endmodule

// File: tb/tb_command_source_arbiter.sv
// tb/tb_command_source_arbiter.sv - bench for command_source_arbiter: directed timeout/reset plus randomized frames vs. frame-level model
module tb_command_source_arbiter;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        sv [2];
    logic [7:0]  sb [2];
    logic        sl [2];
    logic        ctrl_next = 1'b0;

    logic        s0_ready, s1_ready, ctrl_valid, grant, busy, abort, abort_src;
    logic [7:0]  ctrl_byte;
    logic [15:0] bytes_fwd;

    command_source_arbiter #(.FRAME_TIMEOUT_CYCLES(TMO)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .s0_byte    (sb[0]),
        .s0_valid   (sv[0]),
        .s0_last    (sl[0]),
        .s0_ready   (s0_ready),
        .s1_byte    (sb[1]),
        .s1_valid   (sv[1]),
        .s1_last    (sl[1]),
        .s1_ready   (s1_ready),
        .ctrl_byte  (ctrl_byte),
        .ctrl_valid (ctrl_valid),
        .ctrl_next  (ctrl_next),
        .grant      (grant),
        .busy       (busy),
        .abort      (abort),
        .abort_src  (abort_src),
        .bytes_fwd  (bytes_fwd)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Per-source frame contents {last, byte}: q* drive the sources, e* are the expected stream.
    logic [8:0]  q0[$], q1[$], e0[$], e1[$];
    int          gap [2];
    bit          m_idle, m_src, m_last, cv_prev, cur_last, consumed, v0, v1;
    logic [15:0] m_cnt;
    logic [8:0]  exp_e, popped;
    logic [7:0]  held;
    int          nwait, n;

    initial begin
        for (int i = 0; i < 2; i++) begin
            sv[i] = 1'b0; sb[i] = 8'h00; sl[i] = 1'b0; gap[i] = 0;
        end
        tick(); tick();
        chk("reset_outputs", {s0_ready, s1_ready, ctrl_byte, ctrl_valid, grant, busy,
                              abort, abort_src, bytes_fwd}, 32'h0);
        reset_n = 1'b1;

        // s0 sends one non-last byte and then stalls; s1 waits behind it.
        sb[0] = 8'h02; sl[0] = 1'b0; sv[0] = 1'b1;
        tick(); tick();
        chk("to_ready", {s1_ready, s0_ready}, 32'h1);
        chk("to_byte", ctrl_byte, 32'h02);
        chk("to_valid", ctrl_valid, 32'h1);
        sv[0] = 1'b0; ctrl_next = 1'b1;
        sb[1] = 8'h5A; sl[1] = 1'b1; sv[1] = 1'b1;
        tick();
        ctrl_next = 1'b0;
        chk("to_bytes", bytes_fwd, 32'h1);
        n = 0;
        while (!abort && n < 100) begin
            tick(); n++;
        end
        chk("to_cycles", n, TMO);
        chk("to_src", abort_src, 32'h0);
        chk("to_busy", busy, 32'h0);
        tick();
        chk("to_abort_pulse", abort, 32'h0);
        chk("to_regrant", {busy, grant}, 32'h3);
        tick();
        chk("rs_byte", {ctrl_valid, ctrl_byte}, 32'h15A);
        sv[1] = 1'b0;

        // Reset with a byte in flight: dropped, no further ready.
        reset_n = 1'b0;
        tick();
        chk("rs_outputs", {s0_ready, s1_ready, ctrl_byte, ctrl_valid, grant, busy,
                           abort, abort_src, bytes_fwd}, 32'h0);
        reset_n = 1'b1;

        for (int f = 0; f < 20; f++) begin
            int len;
            logic [8:0] w;
            len = $urandom_range(1, 4);
            for (int b = 0; b < len; b++) begin
                w = {(b == len - 1), 8'($urandom)};
                q0.push_back(w); e0.push_back(w);
            end
            len = $urandom_range(1, 4);
            for (int b = 0; b < len; b++) begin
                w = {(b == len - 1), 8'($urandom)};
                q1.push_back(w); e1.push_back(w);
            end
        end
        sv[0] = 1'b1; sb[0] = q0[0][7:0]; sl[0] = q0[0][8];
        sv[1] = 1'b1; sb[1] = q1[0][7:0]; sl[1] = q1[0][8];
        m_idle = 1'b1; m_last = 1'b1; m_src = 1'b0; m_cnt = 16'h0;
        cv_prev = 1'b0; cur_last = 1'b0; nwait = 0; held = 8'h00;

        n = 0;
        while (!(q0.size() == 0 && q1.size() == 0 && e0.size() == 0 && e1.size() == 0
                 && m_idle && !ctrl_valid) && n < 20000) begin
            v0 = sv[0]; v1 = sv[1];
            tick(); n++;
            // Frame-level model: a free arbiter picks the lone requester, or alternates on a tie.
            if (m_idle && (v0 || v1)) begin
                m_src  = (v0 && v1) ? !m_last : v1;
                m_idle = 1'b0;
            end
            consumed = ctrl_next && cv_prev;
            if (consumed) begin
                m_cnt++;
                if (cur_last) begin
                    m_idle = 1'b1;
                    m_last = m_src;
                end
            end
            ctrl_next = 1'b0;

            if (consumed) begin
                chk("gap_low", ctrl_valid, 32'h0);
                chk("bytes_fwd", bytes_fwd, m_cnt);
            end
            if (ctrl_valid && !cv_prev) begin
                if ((m_src ? e1.size() : e0.size()) == 0) begin
                    chk("unexpected_byte", ctrl_byte, 32'hFFFF);
                    exp_e = 9'h100;
                end else begin
                    exp_e = m_src ? e1.pop_front() : e0.pop_front();
                    chk("byte", ctrl_byte, exp_e[7:0]);
                end
                cur_last = exp_e[8];
                chk("grant", {busy, grant}, {1'b1, m_src});
                chk("ready", {s1_ready, s0_ready}, m_src ? 32'h2 : 32'h1);
                held  = ctrl_byte;
                nwait = $urandom_range(0, 10);
            end else begin
                chk("no_ready", {abort, s1_ready, s0_ready}, 32'h0);
            end
            if (ctrl_valid && cv_prev)
                chk("hold", ctrl_byte, held);
            if (ctrl_valid) begin
                if (nwait == 0) ctrl_next = 1'b1;
                else nwait--;
            end
            cv_prev = ctrl_valid;

            // Source models: advance on ready, random stalls between bytes and frames.
            if (s0_ready && q0.size() > 0) begin
                popped = q0.pop_front();
                gap[0] = popped[8] ? $urandom_range(0, 3) : $urandom_range(0, 2);
            end
            if (s1_ready && q1.size() > 0) begin
                popped = q1.pop_front();
                gap[1] = popped[8] ? $urandom_range(0, 3) : $urandom_range(0, 2);
            end
            sv[0] = (q0.size() > 0) && (gap[0] == 0);
            sv[1] = (q1.size() > 0) && (gap[1] == 0);
            if (q0.size() > 0) begin sb[0] = q0[0][7:0]; sl[0] = q0[0][8]; end
            if (q1.size() > 0) begin sb[1] = q1[0][7:0]; sl[1] = q1[0][8]; end
            for (int i = 0; i < 2; i++)
                if (gap[i] > 0) gap[i]--;
        end
        chk("random_done", (n < 20000), 32'h1);
        chk("final_bytes", bytes_fwd, m_cnt);
        chk("final_idle", busy, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
